mult64_seq_ctrl: RTL and testbench

- Sequential controller for an unsigned 64x64 -> 128 multiply. It time-multiplexes a single adder_64 through a radix-2 shift-add loop, one add per cycle.
- Sits in front of the arithmetic datapath as the area-efficient alternative to the combinational 64-bit multiplier.
- Operands enter through a valid/ready handshake; the 128-bit product leaves through a separate valid/ready handshake.

---
 rtl/mult64_seq_ctrl_pkg.sv | 18 +
 rtl/adder_64.sv | 16 +
 rtl/mult64_seq_ctrl.sv | 95 +++++++++
 tb/tb_mult64_seq_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mult64_seq_ctrl_pkg.sv
// Shared definitions for the sequential 64x64 multiplier controller.
//   WIDTH  : operand width (only 64 is supported with adder_64)
//   CNT_W  : iteration counter width, wide enough to hold WIDTH without wrap
//   PROD_W : product width
//   state_t: controller states
package mult64_seq_ctrl_pkg;

  localparam int WIDTH  = 64;
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_64.sv
// 64-bit unsigned adder with carry-in and carry-out, purely combinational.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out
module adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/mult64_seq_ctrl.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier. One shared adder_64
// performs one shift-add step per cycle; WIDTH cycles per product.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake, A/B sampled at the accept edge
//   A, B                 : multiplicand, multiplier (unsigned)
//   out_valid/out_ready  : product handshake
//   product              : A*B, held stable while out_valid is high, else 0
//   busy                 : high in RUN or DONE
//
// state | meaning
// IDLE  | ready for operands
// RUN   | shift-add iterations, cnt counts 0..WIDTH-1
// DONE  | product presented, waiting for out_ready
module mult64_seq_ctrl #(
  parameter int WIDTH = mult64_seq_ctrl_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  import mult64_seq_ctrl_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m, hi, lo;
  logic [WIDTH-1:0] addend, sum;
  logic             carry;

  assign addend = lo[0] ? m : '0;

  adder_64 u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            m   <= A;
            lo  <= B;
            hi  <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          // carry becomes the new top bit, sum LSB shifts into lo
          hi  <= {carry, sum[WIDTH-1:1]};
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // only a completed result is ever visible
  assign product   = out_valid ? {hi, lo} : '0;

endmodule

// File: tb/tb_mult64_seq_ctrl.sv
module tb_mult64_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  A;
  logic [63:0]  B;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] product;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  mult64_seq_ctrl #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input int stall, input bit disturb,
                        input bit chk_lat);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    A = a;
    B = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    n = 0;
    while (!out_valid && n < 200) begin
      if (disturb) begin
        A = ~a;
        B = 64'(n) ^ b ^ 64'h5555;
        in_valid = (n >= 5 && n < 15);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (chk_lat) chk({tag, "_latency"}, 128'(n), 128'(64));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_product"}, product, exp);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_stall_product"}, product, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_post_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [63:0]  ra, rb;
    logic [127:0] rexp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    step();
    step();
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_product",   product,         128'(0));
    rst = 1'b0;
    step();

    run_op("basic", 64'd3, 64'd5, 128'd15, 0, 1'b0, 1'b1);
    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, 1'b0, 1'b1);
    run_op("zero_a", 64'd0, 64'hDEAD_BEEF, 128'd0, 0, 1'b0, 1'b1);
    run_op("backpressure", 64'd1000, 64'd1000, 128'd1000000, 10, 1'b0, 1'b0);
    run_op("ignored_in", 64'h1_0000_0000, 64'h1_0000_0000,
           128'h1_0000_0000_0000_0000, 0, 1'b1, 1'b1);
    run_op("b_zero", 64'h1234_5678_9ABC_DEF0, 64'd0, 128'd0, 0, 1'b0, 1'b1);

    // reset during RUN
    A = 64'd11;
    B = 64'd13;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("midrst_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready",  128'(in_ready),  128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy",      128'(busy),      128'(0));
    chk("midrst_product",   product,         128'(0));
    for (int i = 0; i < 70; i++) begin
      step();
      if (out_valid) break;
    end
    chk("midrst_no_stale", 128'(out_valid), 128'(0));
    run_op("after_rst", 64'd7, 64'd9, 128'd63, 0, 1'b0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rexp = {64'd0, ra} * {64'd0, rb};
      run_op("rand", ra, rb, rexp, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
